// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor: direct-mapped branch target buffer for the OTTER fetch stage.
// Predicts the next fetch PC from the current fetch PC and learns from branches and
// jumps resolved in Execute. Each entry holds a tag, a target, a jump flag and a
// saturating direction counter. A saturating counter records resolved mispredictions.
module otter_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter encodings: weakly taken on allocation, weakly not-taken after reset.
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;

  // Table held in flops so the whole array can be invalidated in one cycle.
  logic             entry_valid   [ENTRIES];
  logic [TAG_W-1:0] entry_tag     [ENTRIES];
  logic [31:0]      entry_target  [ENTRIES];
  logic             entry_is_jump [ENTRIES];
  logic [CTR_W-1:0] entry_ctr     [ENTRIES];

  logic [31:0]      mispred_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             if_hit;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_next;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+2 +: TAG_W];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];

  // PC bits outside index/tag (byte offset, high bits) do not take part in matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, upd_pc};

  assign mispred_cnt = mispred_cnt_q;

  // Lookup: zero-latency prediction from the current (pre-update) table contents.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    if_hit      = 1'b0;
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if_hit      = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    pred_taken  = if_hit && (entry_is_jump[if_idx] || entry_ctr[if_idx][CTR_W-1]);
    if (pred_taken) pred_target = entry_target[if_idx];
  end

  // Update-side hit detection and saturating next counter value.
  always_comb begin
    upd_hit  = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);
    ctr_next = entry_ctr[upd_idx];
    if (upd_taken) begin
      if (entry_ctr[upd_idx] != CTR_MAX) ctr_next = entry_ctr[upd_idx] + CTR_W'(1);
    end else begin
      if (entry_ctr[upd_idx] != CTR_MIN) ctr_next = entry_ctr[upd_idx] - CTR_W'(1);
    end
  end

  // Table training, flush and misprediction counting; reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the table is a flop array and the reset state is architecturally visible
      // (weakly not-taken counters), so every entry is cleared here, not just valid.
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]   <= 1'b0;
        entry_tag[i]     <= '0;
        entry_target[i]  <= '0;
        entry_is_jump[i] <= 1'b0;
        entry_ctr[i]     <= CTR_WNT;
      end
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid && upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;

      if (flush) begin
        // Flush only drops validity; counters and targets survive.
        for (int i = 0; i < ENTRIES; i++) entry_valid[i] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_hit) begin
          entry_is_jump[upd_idx] <= upd_is_jump;
          entry_ctr[upd_idx]     <= ctr_next;
          if (upd_taken) entry_target[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          entry_valid[upd_idx]   <= 1'b1;
          entry_tag[upd_idx]     <= upd_tag;
          entry_target[upd_idx]  <= upd_target;
          entry_is_jump[upd_idx] <= upd_is_jump;
          entry_ctr[upd_idx]     <= CTR_WT;
        end
      end
    end
  end

endmodule
